// File: rtl/booth_r4_mul_seq.sv
// Iterative radix-4 Booth 64x64 multiplier: walks the 33 Booth digits of the
// multiplier PP_PER_CYCLE at a time and accumulates into a 130-bit register.
module booth_r4_mul_seq #(
  parameter int PP_PER_CYCLE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic         i_multa_ns,
  input  logic         i_multb_ns,
  input  logic [63:0]  i_multa,
  input  logic [63:0]  i_multb,
  input  logic         i_abort,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [127:0] o_product,
  output logic         o_busy
);

  localparam int NDIG = 33;
  localparam logic [5:0] CNT_STEP = 6'(PP_PER_CYCLE);
  localparam logic [5:0] LAST_CNT = 6'(NDIG - PP_PER_CYCLE);

  if (!(PP_PER_CYCLE == 1 || PP_PER_CYCLE == 3 ||
        PP_PER_CYCLE == 11 || PP_PER_CYCLE == 33)) begin : g_bad_pp
    $error("booth_r4_mul_seq: PP_PER_CYCLE must be 1, 3, 11 or 33");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic signed [65:0]  xa_p0;
  logic        [66:0]  y_p0;
  logic signed [129:0] acc_p0;
  logic signed [129:0] acc_next;
  logic        [5:0]   cnt_p0;
  logic        [127:0] product_p1;
  logic                accept;
  logic                last_step;

  // Booth recoding of one 3-bit multiplier window into a 66-bit partial product.
  function automatic logic signed [65:0] booth_pp(input logic [2:0] dig,
                                                  input logic signed [65:0] xa);
    case (dig)
      3'b001, 3'b010: booth_pp = xa;
      3'b011:         booth_pp = xa <<< 1;
      3'b100:         booth_pp = -(xa <<< 1);
      3'b101, 3'b110: booth_pp = -xa;
      default:        booth_pp = '0;
    endcase
  endfunction

  function automatic logic signed [129:0] pp_term(input logic [66:0] y,
                                                  input logic signed [65:0] xa,
                                                  input logic [6:0] k);
    logic        [66:0]  ysh;
    logic signed [65:0]  pp;
    logic signed [129:0] ext;
    ysh     = y >> {k, 1'b0};
    pp      = booth_pp(ysh[2:0], xa);
    ext     = {{64{pp[65]}}, pp};
    pp_term = ext <<< {k, 1'b0};
  endfunction

  assign accept    = i_req_valid && (state_q == IDLE);
  assign last_step = (cnt_p0 == LAST_CNT);

  always_comb begin
    acc_next = acc_p0;
    for (int j = 0; j < PP_PER_CYCLE; j++) begin
      acc_next = acc_next + pp_term(y_p0, xa_p0, {1'b0, cnt_p0} + 7'(j));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_req_valid) state_d = CALC;
      CALC: begin
        if (i_abort)        state_d = IDLE;
        else if (last_step) state_d = DONE;
      end
      DONE: if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: operand capture at accept
  always_ff @(posedge i_clk) begin
    if (accept) begin
      xa_p0 <= {{2{i_multa_ns & i_multa[63]}}, i_multa};
      y_p0  <= {{2{i_multb_ns & i_multb[63]}}, i_multb, 1'b0};
    end
  end

  // Stage p1: accumulation and product capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      acc_p0     <= '0;
      cnt_p0     <= '0;
      product_p1 <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
          end
        end
        CALC: begin
          if (i_abort) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
          end else begin
            acc_p0 <= acc_next;
            cnt_p0 <= cnt_p0 + CNT_STEP;
            if (last_step) product_p1 <= acc_next[127:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_busy      = (state_q != IDLE);
  assign o_rsp_valid = (state_q == DONE);
  assign o_product   = product_p1;

endmodule
